alu_frame_if: RTL and testbench
===============================

Name: alu_frame_if

Overview:
- Parametrised framing controller between the UART RX/TX FIFOs and the ALU. Generalises the fixed 3-operand-byte command path.
- Receives a frame of opcode, N_OPERANDS operand bytes and a check byte, then validates the check byte and presents the operands to the ALU.
- Returns the result plus its check byte, with inter-byte timeout and backpressure handling.

Parameters:
- NB_DATA, 8: FIFO/operand/result width.
- NB_OPCODE, 6: opcode width, taken from the low bits of the opcode word.
- N_OPERANDS, 2: operands per frame, legal range 1..8.
- ALU_LAT, 1: cycles to wait after operands are presented before sampling i_alu_result, legal range 1..15.
- TIMEOUT_CYCLES, 1024: mid-frame idle limit; 0 disables the timeout.
- ERR_BYTE, 8'hEE: error response word, used only with ERR_RESP_EN.

Ports:
- i_clk  in  1  clock.
- i_reset  in  1  reset.
- i_rx_data  in  NB_DATA  RX FIFO head word, first-word-fall-through.
- i_rx_empty  in  1  RX FIFO empty.
- o_rx_read  out  1  pop the RX FIFO head.
- i_tx_full  in  1  TX FIFO full.
- o_tx_write  out  1  push o_tx_data.
- o_tx_data  out  NB_DATA  word to transmit.
- o_opcode  out  NB_OPCODE  ALU opcode.
- o_operands  out  N_OPERANDS*NB_DATA  operand k at [k*NB_DATA +: NB_DATA]; k=0 is the first received.
- i_alu_result  in  NB_DATA  combinational ALU result.
- o_alu_valid  out  1  1-cycle pulse marking the start of execution.
- o_busy  out  1  high in any state except IDLE.
- o_crc_err  out  1  1-cycle pulse on check-byte mismatch.
- o_timeout  out  1  1-cycle pulse on frame abort.

Behaviour:
- Reset: i_reset, synchronous, active-high; clock i_clk. All outputs and registers reset to 0; state goes to IDLE. Reset mid-frame discards the partial frame; no TX write occurs in the cycle after reset.
- RX handshake:
  - o_rx_read = (state in IDLE, RX_OPND or RX_CRC) && !i_rx_empty, combinational.
  - A word is consumed in every cycle where o_rx_read=1; i_rx_data is captured in that same cycle.
- Check byte: running = XOR of all received full NB_DATA words (opcode word untruncated); expected = running ^ {NB_DATA{1'b1}}.
- State sequence:
  - IDLE: on read, capture the opcode, running=word, idx=0, go to RX_OPND.
  - RX_OPND: on read, operand[idx]=word, running^=word; at idx==N_OPERANDS-1 go to RX_CRC, else idx+1.
  - RX_CRC: on read, compare the word with expected; match goes to EXEC, mismatch pulses o_crc_err and goes to IDLE (or TX_ERR with the feature).
  - EXEC: o_alu_valid=1 in the first cycle; after ALU_LAT cycles register result=i_alu_result and go to TX_RES.
  - TX_RES: when !i_tx_full, o_tx_write=1 with o_tx_data=result, go to TX_CHK.
  - TX_CHK: when !i_tx_full, o_tx_write=1 with o_tx_data=result^all-ones, go to IDLE.
  - TX_ERR: when !i_tx_full, write ERR_BYTE, go to IDLE.
  - Illegal encodings go to IDLE.
- o_tx_write = TX state && !i_tx_full, combinational. o_tx_data is driven from registers and holds its value while the TX FIFO is full; no word is lost or duplicated.
- Latency: the CRC byte is read at cycle t; with ALU_LAT=1 the result write is at t+2 when TX is not full.
- Timeout: an idle counter counts cycles with i_rx_empty=1 in RX_OPND/RX_CRC and clears on every read. Reaching TIMEOUT_CYCLES pulses o_timeout and goes to IDLE (or TX_ERR with the feature). The counter is not active in IDLE.
- o_opcode and o_operands hold their values until overwritten by the next frame's capture. The ALU sees stable inputs throughout EXEC.
- No RX reads occur during EXEC or the TX states; back-to-back frames in the FIFO are processed strictly in order.

Optional Feature:
- ALU_FRAME_IF_ERR_RESP_EN defined: a check mismatch or timeout goes to TX_ERR, emitting a single ERR_BYTE; the o_crc_err/o_timeout pulses still fire.
- Undefined: the TX_ERR state is absent; the errored frame is silently dropped with the pulse only.

Test Plan:
- Default params, ALU=ADD: RX 0x20,0x05,0x03,0xD9 -> o_operands=0x0305, o_alu_valid pulse, TX 0x08 then 0xF7, o_crc_err=0.
- Same frame with check 0x00 -> o_crc_err pulse, no TX (feature off); single TX 0xEE (feature on).
- TIMEOUT_CYCLES=16: RX 0x20,0x05 then empty -> o_timeout exactly 16 cycles after the 0x05 read, state IDLE. The next valid frame returns 0x08,0xF7.
- i_tx_full held high 10 cycles at TX_RES -> o_tx_write=0 and o_tx_data=0x08 held throughout; afterwards 0x08,0xF7 are written exactly once each.
- N_OPERANDS=3: RX 0x01,0x11,0x22,0x44,0x89 -> o_operands=0x442211, valid frame. Reset asserted after the 0x22 read -> no TX; the fresh frame after reset is processed correctly.
- Two complete frames preloaded in the RX FIFO -> two response pairs in order, o_rx_read=0 during EXEC and the TX states.

Source files
------------

// File: rtl/alu_frame_if.sv
// Frame controller between the UART RX/TX FIFOs and the ALU: opcode, N_OPERANDS bytes, check byte in; result and its check byte out.
// Latency: check byte read at cycle t, result written to TX at t+1+ALU_LAT when the TX FIFO is not full.
// Backpressure: RX is popped only when non-empty in the receive states; TX words wait in registers while i_tx_full is high.
// Optional: define ALU_FRAME_IF_ERR_RESP_EN to answer check mismatches and timeouts with a single ERR_BYTE word.
module alu_frame_if #(
  parameter int                  NB_DATA        = 8,
  parameter int                  NB_OPCODE      = 6,
  parameter int                  N_OPERANDS     = 2,
  parameter int                  ALU_LAT        = 1,
  parameter int                  TIMEOUT_CYCLES = 1024,
  parameter logic [NB_DATA-1:0]  ERR_BYTE       = 8'hEE
) (
  input  logic                         i_clk,
  input  logic                         i_reset,
  input  logic [NB_DATA-1:0]           i_rx_data,
  input  logic                         i_rx_empty,
  output logic                         o_rx_read,
  input  logic                         i_tx_full,
  output logic                         o_tx_write,
  output logic [NB_DATA-1:0]           o_tx_data,
  output logic [NB_OPCODE-1:0]         o_opcode,
  output logic [N_OPERANDS*NB_DATA-1:0] o_operands,
  input  logic [NB_DATA-1:0]           i_alu_result,
  output logic                         o_alu_valid,
  output logic                         o_busy,
  output logic                         o_crc_err,
  output logic                         o_timeout
);

  localparam int IW = (N_OPERANDS > 1) ? $clog2(N_OPERANDS) : 1;
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [NB_DATA-1:0] ONES = '1;

  // Reject parameter sets the datapath cannot represent.
  if (N_OPERANDS < 1 || N_OPERANDS > 8 || ALU_LAT < 1 || ALU_LAT > 15 ||
      NB_OPCODE > NB_DATA || $bits(ERR_BYTE) != NB_DATA) begin : g_param_err
    $error("alu_frame_if: illegal parameter set");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_RX_OPND,
    S_RX_CRC,
    S_EXEC,
    S_TX_RES,
    S_TX_CHK
`ifdef ALU_FRAME_IF_ERR_RESP_EN
    , S_TX_ERR
`endif
  } state_t;

  // Where an errored frame goes: an error word response, or straight back to idle.
`ifdef ALU_FRAME_IF_ERR_RESP_EN
  localparam state_t S_ERR_NEXT = S_TX_ERR;
`else
  localparam state_t S_ERR_NEXT = S_IDLE;
`endif

  state_t                        state_q;
  logic [NB_OPCODE-1:0]          opcode_q;
  logic [N_OPERANDS*NB_DATA-1:0] operands_q;
  logic [NB_DATA-1:0]            running_q;
  logic [IW-1:0]                 idx_q;
  logic [3:0]                    lat_q;
  logic [TW-1:0]                 idle_cnt_q, idle_cnt_d;
  logic [NB_DATA-1:0]            tx_data_q;
  logic                          alu_valid_q, crc_err_q, timeout_q;

  logic in_rx, in_tx, rx_read, tx_write, crc_bad, to_hit;

  // FIFO handshakes, error detection and the idle counter's next value.
  always_comb begin
    in_rx = (state_q == S_RX_OPND) || (state_q == S_RX_CRC);
    in_tx = (state_q == S_TX_RES) || (state_q == S_TX_CHK);
`ifdef ALU_FRAME_IF_ERR_RESP_EN
    in_tx = in_tx || (state_q == S_TX_ERR);
`endif
    rx_read  = !i_reset && ((state_q == S_IDLE) || in_rx) && !i_rx_empty;
    tx_write = !i_reset && in_tx && !i_tx_full;
    crc_bad  = (state_q == S_RX_CRC) && rx_read && (i_rx_data != (running_q ^ ONES));
    to_hit   = (TIMEOUT_CYCLES != 0) && in_rx && i_rx_empty &&
               (int'(idle_cnt_q) + 1 == TIMEOUT_CYCLES);
    // Counts only starved cycles inside a frame; any read or abort restarts it.
    idle_cnt_d = (in_rx && i_rx_empty && !to_hit) ? idle_cnt_q + 1'b1 : '0;
  end

  // Frame state machine: capture, check, execute, respond; error pulses are registered.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q     <= S_IDLE;
      opcode_q    <= '0;
      operands_q  <= '0;
      running_q   <= '0;
      idx_q       <= '0;
      lat_q       <= '0;
      idle_cnt_q  <= '0;
      tx_data_q   <= '0;
      alu_valid_q <= 1'b0;
      crc_err_q   <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      alu_valid_q <= 1'b0;
      crc_err_q   <= 1'b0;
      timeout_q   <= 1'b0;
      idle_cnt_q  <= idle_cnt_d;
      case (state_q)
        S_IDLE: begin
          if (rx_read) begin
            opcode_q  <= i_rx_data[NB_OPCODE-1:0];
            running_q <= i_rx_data;
            idx_q     <= '0;
            state_q   <= S_RX_OPND;
          end
        end
        S_RX_OPND: begin
          if (rx_read) begin
            operands_q[int'(idx_q)*NB_DATA +: NB_DATA] <= i_rx_data;
            running_q <= running_q ^ i_rx_data;
            if (idx_q == IW'(N_OPERANDS - 1)) state_q <= S_RX_CRC;
            else idx_q <= idx_q + 1'b1;
          end
        end
        S_RX_CRC: begin
          // Mismatch is handled by the error override below.
          if (rx_read && !crc_bad) begin
            state_q     <= S_EXEC;
            alu_valid_q <= 1'b1;
            lat_q       <= '0;
          end
        end
        S_EXEC: begin
          // Operands are stable here; sample the ALU once its latency has elapsed.
          if (lat_q == 4'(ALU_LAT - 1)) begin
            tx_data_q <= i_alu_result;
            state_q   <= S_TX_RES;
          end else begin
            lat_q <= lat_q + 1'b1;
          end
        end
        S_TX_RES: begin
          if (!i_tx_full) begin
            tx_data_q <= tx_data_q ^ ONES;
            state_q   <= S_TX_CHK;
          end
        end
        S_TX_CHK: begin
          if (!i_tx_full) state_q <= S_IDLE;
        end
`ifdef ALU_FRAME_IF_ERR_RESP_EN
        S_TX_ERR: begin
          if (!i_tx_full) state_q <= S_IDLE;
        end
`endif
        default: state_q <= S_IDLE;
      endcase
      // A bad check byte or a starved frame abandons the frame.
      if (crc_bad || to_hit) begin
        state_q   <= S_ERR_NEXT;
        crc_err_q <= crc_bad;
        timeout_q <= to_hit;
`ifdef ALU_FRAME_IF_ERR_RESP_EN
        tx_data_q <= ERR_BYTE;
`endif
      end
    end
  end

  assign o_rx_read   = rx_read;
  assign o_tx_write  = tx_write;
  assign o_tx_data   = tx_data_q;
  assign o_opcode    = opcode_q;
  assign o_operands  = operands_q;
  assign o_alu_valid = alu_valid_q;
  assign o_busy      = (state_q != S_IDLE);
  assign o_crc_err   = crc_err_q;
  assign o_timeout   = timeout_q;

endmodule

// File: tb/tb_alu_frame_if.sv
// Bench for alu_frame_if: instance A (2 operands, ADD ALU, 16-cycle timeout), instance B (3 operands, SUM ALU, ALU_LAT=2).
// RX FIFOs are bench queues; expected TX words go to a scoreboard queue when a frame is pushed.
// Inputs change 1 ns after the rising edge, outputs are sampled on the falling edge.
module tb_alu_frame_if;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

`ifdef ALU_FRAME_IF_ERR_RESP_EN
  localparam int ERR_TX = 1;
`else
  localparam int ERR_TX = 0;
`endif

  // ---------------- instance A ----------------
  logic        rst_a, rx_empty_a, rx_read_a, tx_full_a, tx_write_a;
  logic [7:0]  rx_data_a, tx_data_a, alu_a;
  logic [5:0]  opc_a;
  logic [15:0] ops_a;
  logic        valid_a, busy_a, crc_a, to_a;
  logic [7:0]  rxq_a[$];
  logic [7:0]  expq_a[$];
  int n_tx_a = 0, n_valid_a = 0, n_crc_a = 0, n_to_a = 0, viol_a = 0;
  int last_rd_cyc_a = 0, to_cyc_a = 0;
  logic to_busy_a = 1'b0, exec_a = 1'b0, rd_pend_a = 1'b0;

  assign alu_a = ops_a[7:0] + ops_a[15:8];

  alu_frame_if #(.NB_DATA(8), .NB_OPCODE(6), .N_OPERANDS(2), .ALU_LAT(1),
                 .TIMEOUT_CYCLES(16), .ERR_BYTE(8'hEE)) u_dut_a (
    .i_clk(clk), .i_reset(rst_a),
    .i_rx_data(rx_data_a), .i_rx_empty(rx_empty_a), .o_rx_read(rx_read_a),
    .i_tx_full(tx_full_a), .o_tx_write(tx_write_a), .o_tx_data(tx_data_a),
    .o_opcode(opc_a), .o_operands(ops_a), .i_alu_result(alu_a),
    .o_alu_valid(valid_a), .o_busy(busy_a), .o_crc_err(crc_a), .o_timeout(to_a)
  );

  // ---------------- instance B ----------------
  logic        rst_b, rx_empty_b, rx_read_b, tx_full_b, tx_write_b;
  logic [7:0]  rx_data_b, tx_data_b, alu_b;
  logic [5:0]  opc_b;
  logic [23:0] ops_b;
  logic        valid_b, busy_b, crc_b, to_b;
  logic [7:0]  rxq_b[$];
  logic [7:0]  expq_b[$];
  int n_tx_b = 0, n_valid_b = 0;
  logic rd_pend_b = 1'b0;

  assign alu_b = ops_b[7:0] + ops_b[15:8] + ops_b[23:16];

  alu_frame_if #(.NB_DATA(8), .NB_OPCODE(6), .N_OPERANDS(3), .ALU_LAT(2),
                 .TIMEOUT_CYCLES(1024), .ERR_BYTE(8'hEE)) u_dut_b (
    .i_clk(clk), .i_reset(rst_b),
    .i_rx_data(rx_data_b), .i_rx_empty(rx_empty_b), .o_rx_read(rx_read_b),
    .i_tx_full(tx_full_b), .o_tx_write(tx_write_b), .o_tx_data(tx_data_b),
    .o_opcode(opc_b), .o_operands(ops_b), .i_alu_result(alu_b),
    .o_alu_valid(valid_b), .o_busy(busy_b), .o_crc_err(crc_b), .o_timeout(to_b)
  );

  task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  task automatic refresh_a();
    rx_empty_a = (rxq_a.size() == 0);
    rx_data_a  = rx_empty_a ? 8'h00 : rxq_a[0];
  endtask

  task automatic refresh_b();
    rx_empty_b = (rxq_b.size() == 0);
    rx_data_b  = rx_empty_b ? 8'h00 : rxq_b[0];
  endtask

  task automatic push_a(input logic [7:0] b);
    rxq_a.push_back(b);
    refresh_a();
  endtask

  task automatic push_b(input logic [7:0] b);
    rxq_b.push_back(b);
    refresh_b();
  endtask

  // RX FIFO pop: the word seen with o_rx_read high is consumed at the following edge.
  always @(posedge clk) begin
    #2;
    if (rd_pend_a && rxq_a.size() > 0) begin
      void'(rxq_a.pop_front());
      refresh_a();
    end
    if (rd_pend_b && rxq_b.size() > 0) begin
      void'(rxq_b.pop_front());
      refresh_b();
    end
  end

  // Monitor A: pulse counters, read-while-executing watch, TX scoreboard.
  always @(negedge clk) begin
    logic [7:0] e;
    rd_pend_a = rx_read_a;
    if (!busy_a) exec_a = 1'b0;
    if (valid_a) begin n_valid_a++; exec_a = 1'b1; end
    if (exec_a && rx_read_a) viol_a++;
    if (crc_a) n_crc_a++;
    if (to_a) begin n_to_a++; to_cyc_a = cyc; to_busy_a = busy_a; end
    if (rx_read_a) last_rd_cyc_a = cyc;
    if (tx_write_a) begin
      n_tx_a++;
      if (expq_a.size() == 0) begin
        checks++; errors++;
        $display("FAIL tx_unexpected_a: got %02h, nothing expected", tx_data_a);
      end else begin
        e = expq_a.pop_front();
        check("tx_word_a", tx_data_a, e);
      end
    end
  end

  // Monitor B: TX scoreboard and execution pulses.
  always @(negedge clk) begin
    logic [7:0] e;
    rd_pend_b = rx_read_b;
    if (valid_b) n_valid_b++;
    if (tx_write_b) begin
      n_tx_b++;
      if (expq_b.size() == 0) begin
        checks++; errors++;
        $display("FAIL tx_unexpected_b: got %02h, nothing expected", tx_data_b);
      end else begin
        e = expq_b.pop_front();
        check("tx_word_b", tx_data_b, e);
      end
    end
  end

  task automatic wait_done_a(input string nm);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(rxq_a.size() == 0 && !busy_a && expq_a.size() == 0) && n < 400);
    if (n >= 400) begin
      checks++; errors++;
      $display("FAIL %s_done: busy=%0d rxq=%0d expq=%0d after %0d cycles", nm, busy_a, rxq_a.size(), expq_a.size(), n);
    end
    @(posedge clk); #1;
  endtask

  task automatic wait_done_b(input string nm);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(rxq_b.size() == 0 && !busy_b && expq_b.size() == 0) && n < 400);
    if (n >= 400) begin
      checks++; errors++;
      $display("FAIL %s_done: busy=%0d rxq=%0d expq=%0d after %0d cycles", nm, busy_b, rxq_b.size(), expq_b.size(), n);
    end
    @(posedge clk); #1;
  endtask

  typedef struct {
    logic [7:0]  op, a, b, chk;
    logic [5:0]  exp_opc;
    logic [15:0] exp_ops;
    logic [7:0]  exp_res;
    bit          exp_bad;
  } vec_t;

  initial begin
    vec_t vecs[7];
    int cv, cc, ct, ctb, cvb, bad;

    // check byte = ~(op ^ a ^ b); result = a + b (mod 256)
    vecs[0] = '{8'h20, 8'h05, 8'h03, 8'hD9, 6'h20, 16'h0305, 8'h08, 1'b0};
    vecs[1] = '{8'h20, 8'h05, 8'h03, 8'h00, 6'h20, 16'h0305, 8'h00, 1'b1};
    vecs[2] = '{8'h3F, 8'hFF, 8'h01, 8'h3E, 6'h3F, 16'h01FF, 8'h00, 1'b0};
    vecs[3] = '{8'hC1, 8'h7F, 8'h10, 8'h51, 6'h01, 16'h107F, 8'h8F, 1'b0};
    vecs[4] = '{8'h00, 8'h00, 8'h00, 8'hFF, 6'h00, 16'h0000, 8'h00, 1'b0};
    vecs[5] = '{8'h15, 8'hAA, 8'h55, 8'h14, 6'h15, 16'h55AA, 8'h00, 1'b1};
    vecs[6] = '{8'h2A, 8'hC8, 8'h64, 8'h79, 6'h2A, 16'h64C8, 8'h2C, 1'b0};

    rst_a = 1'b1; rst_b = 1'b1; tx_full_a = 1'b0; tx_full_b = 1'b0;
    refresh_a(); refresh_b();
    repeat (3) @(posedge clk);
    #1; rst_a = 1'b0; rst_b = 1'b0;

    // Reset state
    @(negedge clk);
    check("rst_busy_a", busy_a, 0);
    check("rst_tx_write_a", tx_write_a, 0);
    check("rst_tx_data_a", tx_data_a, 0);
    check("rst_operands_a", ops_a, 0);
    check("rst_opcode_a", opc_a, 0);
    check("rst_pulses_a", {valid_a, crc_a, to_a}, 0);
    check("rst_busy_b", busy_b, 0);
    check("rst_operands_b", ops_b, 0);
    @(posedge clk); #1;

    // Starved frame: timeout 16 edges after the last read, then back to idle
    cv = n_valid_a; cc = n_to_a; ct = n_tx_a;
`ifdef ALU_FRAME_IF_ERR_RESP_EN
    expq_a.push_back(8'hEE);
`endif
    push_a(8'h20); push_a(8'h05);
    wait_done_a("timeout");
    check("timeout_pulses", n_to_a - cc, 1);
    check("timeout_latency", to_cyc_a - last_rd_cyc_a - 1, 16);
    check("timeout_busy", to_busy_a, ERR_TX);
    check("timeout_no_exec", n_valid_a - cv, 0);
    check("timeout_tx_count", n_tx_a - ct, ERR_TX);

    // Table-driven frames on instance A
    for (int i = 0; i < 7; i++) begin
      cv = n_valid_a; cc = n_crc_a; ct = n_tx_a;
      push_a(vecs[i].op); push_a(vecs[i].a); push_a(vecs[i].b); push_a(vecs[i].chk);
      if (!vecs[i].exp_bad) begin
        expq_a.push_back(vecs[i].exp_res);
        expq_a.push_back(~vecs[i].exp_res);
      end else begin
`ifdef ALU_FRAME_IF_ERR_RESP_EN
        expq_a.push_back(8'hEE);
`endif
      end
      wait_done_a($sformatf("vec%0d", i));
      check($sformatf("vec%0d_opcode", i), opc_a, vecs[i].exp_opc);
      check($sformatf("vec%0d_operands", i), ops_a, vecs[i].exp_ops);
      check($sformatf("vec%0d_crc_pulses", i), n_crc_a - cc, vecs[i].exp_bad ? 1 : 0);
      check($sformatf("vec%0d_valid_pulses", i), n_valid_a - cv, vecs[i].exp_bad ? 0 : 1);
      check($sformatf("vec%0d_tx_count", i), n_tx_a - ct, vecs[i].exp_bad ? ERR_TX : 2);
    end

    // TX backpressure: hold the FIFO full while the result is pending
    ct = n_tx_a; bad = 0;
    tx_full_a = 1'b1;
    push_a(8'h20); push_a(8'h05); push_a(8'h03); push_a(8'hD9);
    expq_a.push_back(8'h08); expq_a.push_back(8'hF7);
    repeat (7) @(posedge clk);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (tx_write_a || tx_data_a !== 8'h08 || !busy_a) bad++;
    end
    check("txfull_hold", bad, 0);
    check("txfull_no_writes", n_tx_a - ct, 0);
    @(posedge clk); #1;
    tx_full_a = 1'b0;
    wait_done_a("txfull");
    check("txfull_tx_count", n_tx_a - ct, 2);

    // Two frames preloaded back to back
    cv = n_valid_a; ct = n_tx_a;
    push_a(8'h20); push_a(8'h05); push_a(8'h03); push_a(8'hD9);
    push_a(8'h2A); push_a(8'hC8); push_a(8'h64); push_a(8'h79);
    expq_a.push_back(8'h08); expq_a.push_back(8'hF7);
    expq_a.push_back(8'h2C); expq_a.push_back(8'hD3);
    wait_done_a("b2b");
    check("b2b_tx_count", n_tx_a - ct, 4);
    check("b2b_valid_pulses", n_valid_a - cv, 2);
    check("rx_read_during_exec", viol_a, 0);

    // Instance B: three operands, ALU_LAT=2
    ctb = n_tx_b; cvb = n_valid_b;
    push_b(8'h01); push_b(8'h11); push_b(8'h22); push_b(8'h44); push_b(8'h89);
    expq_b.push_back(8'h77); expq_b.push_back(8'h88);
    wait_done_b("n3");
    check("n3_operands", ops_b, 24'h442211);
    check("n3_opcode", opc_b, 6'h01);
    check("n3_tx_count", n_tx_b - ctb, 2);
    check("n3_valid_pulses", n_valid_b - cvb, 1);

    // Reset in the middle of a frame
    ctb = n_tx_b; cvb = n_valid_b;
    push_b(8'h02); push_b(8'h11); push_b(8'h22);
    for (int n = 0; n < 50 && rxq_b.size() != 0; n++) @(posedge clk);
    @(posedge clk); #1;
    rst_b = 1'b1;
    repeat (2) @(posedge clk);
    #1; rst_b = 1'b0;
    @(negedge clk);
    check("midrst_busy", busy_b, 0);
    check("midrst_operands", ops_b, 0);
    repeat (20) @(posedge clk);
    #1;
    check("midrst_no_tx", n_tx_b - ctb, 0);
    check("midrst_no_exec", n_valid_b - cvb, 0);

    // Fresh frame after reset
    push_b(8'h03); push_b(8'h01); push_b(8'h02); push_b(8'h04); push_b(8'hFB);
    expq_b.push_back(8'h07); expq_b.push_back(8'hF8);
    wait_done_b("postrst");
    check("postrst_operands", ops_b, 24'h040201);
    check("postrst_tx_count", n_tx_b - ctb, 2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

endmodule
